// File: rtl/dmem_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lsu_ctrl
// Description : Load/store sequencer between the memory stage and port 0 of
//               a byte-lane data memory. It turns one byte/half/word request
//               into one or more DMEM beats. Misaligned accesses are split
//               into per-byte beats. Loads are sign/zero-extended, and one
//               response is returned per request.
// Ports       : clk, rst                       - clock, sync active-high reset
//               req_valid/req_ready            - request handshake
//               req_we, req_size, req_signed,
//               req_addr, req_wdata            - request fields
//               resp_valid/resp_err/resp_rdata - single-cycle response
//               wr_en, port_en_0, addr_in_0,
//               data_in, data_out_0            - DMEM port 0
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lsu_ctrl #(
  parameter int WIDTH   = 32,
  parameter int N_LANES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [1:0]         req_size,
  input  logic               req_signed,
  input  logic [WIDTH-1:0]   req_addr,
  input  logic [WIDTH-1:0]   req_wdata,
  output logic               resp_valid,
  output logic               resp_err,
  output logic [WIDTH-1:0]   resp_rdata,
  output logic               wr_en,
  output logic [N_LANES-1:0] port_en_0,
  output logic [WIDTH-1:0]   addr_in_0,
  output logic [WIDTH-1:0]   data_in,
  input  logic [WIDTH-1:0]   data_out_0
);

  localparam logic [2:0] c_S_IDLE = 3'd0;
  localparam logic [2:0] c_S_ST   = 3'd1;
  localparam logic [2:0] c_S_RDI  = 3'd2;
  localparam logic [2:0] c_S_RDC  = 3'd3;
  localparam logic [2:0] c_S_DONE = 3'd4;

  logic [2:0]         r_state;
  logic [2:0]         w_next;
  logic               r_we;
  logic [1:0]         r_size;
  logic               r_signed;
  logic [WIDTH-1:0]   r_addr;
  logic [WIDTH-1:0]   r_wdata;
  logic [WIDTH-1:0]   r_rdata;
  logic [1:0]         r_k;

  logic               w_accept;
  logic               w_mis;
  logic               w_last;
  logic [1:0]         w_nb_m1;
  logic [WIDTH-1:0]   w_a;
  logic [N_LANES-1:0] w_lane;
  logic [7:0]         w_wbyte;
  logic [WIDTH-1:0]   w_store_data;
  logic [WIDTH-1:0]   w_ext;

  assign w_accept = req_valid & req_ready;

  // Number of bytes minus one; only meaningful for the legal sizes.
  always_comb begin
    case (r_size)
      2'd1:    w_nb_m1 = 2'd1;
      2'd2:    w_nb_m1 = 2'd3;
      default: w_nb_m1 = 2'd0;
    endcase
  end

  assign w_mis  = ((r_size == 2'd1) && r_addr[0]) ||
                  ((r_size == 2'd2) && (r_addr[1:0] != 2'b00));
  // Aligned accesses always finish after their single beat.
  assign w_last = !w_mis || (r_k == w_nb_m1);
  assign w_a    = r_addr + {{(WIDTH-2){1'b0}}, r_k};

  always_comb begin
    if (w_mis) begin
      w_lane = N_LANES'(1) << w_a[1:0];
    end else begin
      case (r_size)
        2'd0:    w_lane = N_LANES'(1) << r_addr[1:0];
        2'd1:    w_lane = r_addr[1] ? N_LANES'(12) : N_LANES'(3);
        2'd2:    w_lane = N_LANES'(15);
        default: w_lane = '0;
      endcase
    end
  end

  assign w_wbyte = r_wdata[{r_k, 3'b000} +: 8];

  always_comb begin
    if (w_mis) begin
      w_store_data = {{(WIDTH-8){1'b0}}, w_wbyte};
    end else begin
      case (r_size)
        2'd0:    w_store_data = {{(WIDTH-8){1'b0}}, r_wdata[7:0]};
        2'd1:    w_store_data = {{(WIDTH-16){1'b0}}, r_wdata[15:0]};
        default: w_store_data = r_wdata;
      endcase
    end
  end

  always_comb begin
    case (r_size)
      2'd0:    w_ext = {{(WIDTH-8){r_signed & r_rdata[7]}}, r_rdata[7:0]};
      2'd1:    w_ext = {{(WIDTH-16){r_signed & r_rdata[15]}}, r_rdata[15:0]};
      2'd2:    w_ext = r_rdata;
      default: w_ext = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_S_IDLE: begin
        if (w_accept) begin
          if (req_size == 2'd3) w_next = c_S_DONE;
          else if (req_we)      w_next = c_S_ST;
          else                  w_next = c_S_RDI;
        end
      end
      c_S_ST:   w_next = w_last ? c_S_DONE : c_S_ST;
      c_S_RDI:  w_next = c_S_RDC;
      c_S_RDC:  w_next = w_last ? c_S_DONE : c_S_RDI;
      c_S_DONE: w_next = c_S_IDLE;
      default:  w_next = c_S_IDLE;
    endcase
  end

  // Output logic. Everything is forced low while rst is high so that a beat
  // in flight when reset arrives is never written.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    wr_en      = 1'b0;
    port_en_0  = '0;
    addr_in_0  = '0;
    data_in    = '0;
    if (!rst) begin
      case (r_state)
        c_S_IDLE: req_ready = 1'b1;
        c_S_ST: begin
          wr_en     = 1'b1;
          port_en_0 = w_lane;
          addr_in_0 = {2'b00, w_a[WIDTH-1:2]};
          data_in   = w_store_data;
        end
        c_S_RDI: begin
          port_en_0 = w_lane;
          addr_in_0 = {2'b00, w_a[WIDTH-1:2]};
        end
        c_S_DONE: begin
          resp_valid = 1'b1;
          resp_err   = (r_size == 2'd3);
          resp_rdata = (r_we || (r_size == 2'd3)) ? '0 : w_ext;
        end
        default: ;
      endcase
    end
  end

  // Request latch, beat counter and load assembly register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_size   <= 2'd0;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_k      <= 2'd0;
    end else if (w_accept) begin
      r_we     <= req_we;
      r_size   <= req_size;
      r_signed <= req_signed;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
      r_rdata  <= '0;
      r_k      <= 2'd0;
    end else begin
      case (r_state)
        c_S_ST: r_k <= r_k + 2'd1;
        c_S_RDC: begin
          // DMEM returns the enabled lanes low-justified, so a split
          // access always finds its byte in bits [7:0].
          if (w_mis) begin
            r_rdata[{r_k, 3'b000} +: 8] <= data_out_0[7:0];
          end else begin
            r_rdata <= data_out_0;
          end
          r_k <= r_k + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_lsu_ctrl
// Description : Self-checking bench for dmem_lsu_ctrl. Contains a byte-lane
//               DMEM model on port 0 and a byte-array reference model that
//               predicts the per-cycle DMEM beats and the response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_lsu_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        wr_en;
  logic [3:0]  port_en_0;
  logic [31:0] addr_in_0;
  logic [31:0] data_in;
  logic [31:0] data_out_0;

  dmem_lsu_ctrl #(.WIDTH(32), .N_LANES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .wr_en      (wr_en),
    .port_en_0  (port_en_0),
    .addr_in_0  (addr_in_0),
    .data_in    (data_in),
    .data_out_0 (data_out_0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mask(input int n);
    logic [63:0] m;
    m = (64'd1 << (8 * n)) - 64'd1;
    return m[31:0];
  endfunction

  // ---------------- DMEM port-0 model: 1024 words x 4 byte lanes ----------
  logic [7:0] dm [0:4095];

  always @(posedge clk) begin : mem_p
    int          j;
    int          base;
    logic [31:0] rd;
    if (port_en_0 != 4'd0) begin
      base = int'(addr_in_0[9:0]) * 4;
      j    = 0;
      rd   = 32'd0;
      for (int l = 0; l < 4; l++) begin
        if (port_en_0[l]) begin
          if (wr_en) dm[base + l] <= data_in[8*j +: 8];
          else       rd[8*j +: 8] = dm[base + l];
          j++;
        end
      end
      if (!wr_en) data_out_0 <= rd;
    end
  end

  // ---------------- Reference model ---------------------------------------
  typedef struct {
    logic        wr;
    logic [3:0]  pe;
    logic [31:0] ad;
    logic [31:0] di;
    int          dbytes;
    logic [31:0] wb;
    logic        rv;
    logic        re;
    logic [31:0] rd;
  } exp_t;

  exp_t       q[$];
  logic [7:0] ref_mem [0:4095];

  // Expected per-cycle activity starting the cycle after accept.
  task automatic push_sched(input logic we, input logic [1:0] sz, input logic sg,
                            input logic [31:0] ad, input logic [31:0] wd);
    exp_t        e;
    int          n;
    int          cnt;
    int          start;
    int          beats;
    bit          aligned;
    logic [31:0] a;
    logic [31:0] v;
    if (sz == 2'd3) begin
      e = '{default: 0};
      e.rv = 1'b1;
      e.re = 1'b1;
      q.push_back(e);
      return;
    end
    n       = 1 << sz;
    aligned = (ad % n) == 0;
    beats   = aligned ? 1 : n;
    cnt     = aligned ? n : 1;
    for (int k = 0; k < beats; k++) begin
      a     = ad + k;
      start = aligned ? 0 : k;
      e     = '{default: 0};
      e.pe  = 4'(((1 << cnt) - 1) << (a % 4));
      e.ad  = a >> 2;
      if (we) begin
        e.wr     = 1'b1;
        e.di     = (wd >> (8 * start)) & mask(cnt);
        e.dbytes = cnt;
        e.wb     = a;
        q.push_back(e);
      end else begin
        q.push_back(e);
        e = '{default: 0};
        q.push_back(e);
      end
    end
    e    = '{default: 0};
    e.rv = 1'b1;
    if (!we) begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v |= 32'(ref_mem[(ad + i) % 4096]) << (8 * i);
      if (sg && v[8*n-1]) v |= ~mask(n);
      e.rd = v;
    end
    q.push_back(e);
  endtask

  // ---------------- Compare process ---------------------------------------
  logic [31:0] last_rdata;
  logic        last_err;
  int          resp_cyc;
  logic [31:0] log_ad[$];
  logic [3:0]  log_pe[$];
  logic [31:0] log_di[$];

  always @(negedge clk) begin : cmp_p
    exp_t e;
    if (wr_en) begin
      log_ad.push_back(addr_in_0);
      log_pe.push_back(port_en_0);
      log_di.push_back(data_in);
    end
    if (resp_valid) begin
      last_rdata = resp_rdata;
      last_err   = resp_err;
      resp_cyc   = cyc;
    end
    if (!rst) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("wr_en", {31'd0, wr_en}, {31'd0, e.wr});
        chk("port_en_0", {28'd0, port_en_0}, {28'd0, e.pe});
        if (e.pe != 4'd0) chk("addr_in_0", addr_in_0, e.ad);
        if (e.wr) begin
          chk("data_in", data_in & mask(e.dbytes), e.di);
          for (int i = 0; i < e.dbytes; i++) ref_mem[(e.wb + i) % 4096] = e.di[8*i +: 8];
        end
        chk("resp_valid", {31'd0, resp_valid}, {31'd0, e.rv});
        if (e.rv) begin
          chk("resp_err", {31'd0, resp_err}, {31'd0, e.re});
          chk("resp_rdata", resp_rdata, e.rd);
        end
        chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
      end else begin
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        chk("resp_valid_idle", {31'd0, resp_valid}, 32'd0);
        chk("wr_en_idle", {31'd0, wr_en}, 32'd0);
        chk("port_en_idle", {28'd0, port_en_0}, 32'd0);
      end
    end
  end

  // ---------------- Driver ------------------------------------------------
  int acc_cyc;

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
    end
    if (q.size() != 0) begin
      chk("completion_timeout", q.size(), 32'd0);
      q.delete();
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] ad, input logic [31:0] wd);
    @(posedge clk); #1;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = ad;
    req_wdata  = wd;
    req_valid  = 1'b1;
    acc_cyc    = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
    push_sched(we, sz, sg, ad, wd);
    wait_idle();
  endtask

  task automatic chk_resp(input string name, input logic [31:0] rdata, input int lat);
    chk({name, "_rdata"}, last_rdata, rdata);
    chk({name, "_latency"}, resp_cyc - acc_cyc, lat);
  endtask

  task automatic clear_log();
    log_ad.delete();
    log_pe.delete();
    log_di.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      dm[i]      = 8'h00;
      ref_mem[i] = 8'h00;
    end
    data_out_0 = 32'd0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    last_rdata = 32'd0;
    last_err   = 1'b0;
    resp_cyc   = 0;
    acc_cyc    = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_port_en", {28'd0, port_en_0}, 32'd0);
    chk("rst_addr_in", addr_in_0, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // Aligned word store/load
    clear_log();
    do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
    chk("sw_beats", log_pe.size(), 32'd1);
    if (log_pe.size() == 1) begin
      chk("sw_pe", {28'd0, log_pe[0]}, 32'd15);
      chk("sw_ad", log_ad[0], 32'h40);
    end
    chk("sw_latency", resp_cyc - acc_cyc, 32'd2);
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    chk_resp("lw_100", 32'hDEADBEEF, 3);

    // Aligned byte store, signed and unsigned loads
    clear_log();
    do_req(1'b1, 2'd0, 1'b0, 32'h102, 32'h00000080);
    if (log_pe.size() == 1) begin
      chk("sb_pe", {28'd0, log_pe[0]}, 32'd4);
      chk("sb_di", log_di[0], 32'h00000080);
    end else chk("sb_beats", log_pe.size(), 32'd1);
    do_req(1'b0, 2'd0, 1'b1, 32'h102, 32'h0);
    chk_resp("lb_102", 32'hFFFFFF80, 3);
    do_req(1'b0, 2'd0, 1'b0, 32'h102, 32'h0);
    chk_resp("lbu_102", 32'h00000080, 3);

    // Misaligned word store: four byte beats, then load back
    clear_log();
    do_req(1'b1, 2'd2, 1'b0, 32'h0FE, 32'h11223344);
    chk("msw_beats", log_pe.size(), 32'd4);
    if (log_pe.size() == 4) begin
      chk("msw_b0", {log_ad[0][15:0], 4'd0, log_pe[0], log_di[0][7:0]}, 32'h003F_0444);
      chk("msw_b1", {log_ad[1][15:0], 4'd0, log_pe[1], log_di[1][7:0]}, 32'h003F_0833);
      chk("msw_b2", {log_ad[2][15:0], 4'd0, log_pe[2], log_di[2][7:0]}, 32'h0040_0122);
      chk("msw_b3", {log_ad[3][15:0], 4'd0, log_pe[3], log_di[3][7:0]}, 32'h0040_0211);
    end
    chk("msw_latency", resp_cyc - acc_cyc, 32'd5);
    do_req(1'b0, 2'd2, 1'b0, 32'h0FE, 32'h0);
    chk_resp("mlw_0fe", 32'h11223344, 9);

    // Misaligned signed half loads across a word boundary
    do_req(1'b1, 2'd0, 1'b0, 32'h003, 32'h000000F0);
    do_req(1'b1, 2'd0, 1'b0, 32'h004, 32'h0000007F);
    do_req(1'b0, 2'd1, 1'b1, 32'h003, 32'h0);
    chk_resp("mlh_pos", 32'h00007FF0, 5);
    do_req(1'b1, 2'd0, 1'b0, 32'h003, 32'h0000007F);
    do_req(1'b1, 2'd0, 1'b0, 32'h004, 32'h000000F0);
    do_req(1'b0, 2'd1, 1'b1, 32'h003, 32'h0);
    chk_resp("mlh_neg", 32'hFFFFF07F, 5);

    // Aligned upper half with junk in the high store bits
    clear_log();
    do_req(1'b1, 2'd1, 1'b0, 32'h106, 32'h1234BEEF);
    if (log_pe.size() == 1) chk("sh_pe", {28'd0, log_pe[0]}, 32'd12);
    else chk("sh_beats", log_pe.size(), 32'd1);
    do_req(1'b0, 2'd1, 1'b0, 32'h106, 32'h0);
    chk_resp("lhu_106", 32'h0000BEEF, 3);
    do_req(1'b0, 2'd1, 1'b1, 32'h106, 32'h0);
    chk_resp("lh_106", 32'hFFFFBEEF, 3);

    // Illegal size
    do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
    chk_resp("illegal", 32'h0, 1);
    chk("illegal_err", {31'd0, last_err}, 32'd1);

    // Address wrap at the DMEM depth
    do_req(1'b1, 2'd2, 1'b0, 32'h1000, 32'h0BADF00D);
    do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    chk_resp("wrap", 32'h0BADF00D, 3);

    // Requests while busy are ignored
    @(posedge clk); #1;
    req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h300; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
    acc_cyc = cyc;
    @(posedge clk); #1;
    push_sched(1'b1, 2'd2, 1'b0, 32'h300, 32'hCAFEF00D);
    req_we = 1'b1; req_addr = 32'h304; req_wdata = 32'h87654321;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_idle();
    do_req(1'b0, 2'd2, 1'b0, 32'h304, 32'h0);
    chk_resp("busy_ignored", 32'h0, 3);
    do_req(1'b0, 2'd2, 1'b0, 32'h300, 32'h0);
    chk_resp("busy_store", 32'hCAFEF00D, 3);

    // Reset during beat 3 of a misaligned word store
    do_req(1'b1, 2'd2, 1'b0, 32'h200, 32'h55555555);
    do_req(1'b1, 2'd2, 1'b0, 32'h204, 32'h55555555);
    @(posedge clk); #1;
    req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h201; req_wdata = 32'hAABBCCDD; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    push_sched(1'b1, 2'd2, 1'b0, 32'h201, 32'hAABBCCDD);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_req_ready", {31'd0, req_ready}, 32'd0);
    chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("abort_resp_err", {31'd0, resp_err}, 32'd0);
    chk("abort_resp_rdata", resp_rdata, 32'd0);
    chk("abort_wr_en", {31'd0, wr_en}, 32'd0);
    chk("abort_port_en", {28'd0, port_en_0}, 32'd0);
    chk("abort_addr_in", addr_in_0, 32'd0);
    chk("abort_data_in", data_in, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_ready_after", {31'd0, req_ready}, 32'd1);
    chk("abort_mem_201", {24'd0, dm[12'h201]}, 32'hDD);
    chk("abort_mem_202", {24'd0, dm[12'h202]}, 32'hCC);
    chk("abort_mem_203", {24'd0, dm[12'h203]}, 32'h55);
    chk("abort_mem_204", {24'd0, dm[12'h204]}, 32'h55);
    do_req(1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
    chk_resp("abort_readback", 32'h55CCDD55, 3);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
